// File: rtl/axi4l_master_bridge.sv
// axi4l_master_bridge: single-outstanding core load/store commands to an AXI4-Lite master (AW/W/AR/R, no B)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      core command handshake; cmd_ready is high only in IDLE
//   cmd_addr/we/wdata/wstrb  command payload, latched on acceptance
//   rsp_valid/rsp_ready      core response handshake
//   rsp_rdata/rsp_err        read data (0 for writes and errors), misalignment error
//   m_axi_aw*/w*/ar*/r*      AXI4-Lite master channels
module axi4l_master_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_we,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RSP} state_t;
    state_t state;
    logic [ADDR_W-1:0] word_addr;
    assign word_addr = {cmd_addr[ADDR_W-1:2], 2'b00};
    assign cmd_ready = state == IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RSP;
                    end else if (cmd_we) begin
                        m_axi_awaddr  <= word_addr;
                        m_axi_wdata   <= cmd_wdata;
                        m_axi_wstrb   <= cmd_wstrb;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= WR;
                    end else begin
                        m_axi_araddr  <= word_addr;
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_A;
                    end
                end
                WR: begin
                    // each channel retires on its own ready; the write is done once neither valid remains pending
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready) m_axi_wvalid <= 1'b0;
                    if ((m_axi_awready || !m_axi_awvalid) && (m_axi_wready || !m_axi_wvalid)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= RSP;
                    end
                end
                RD_A: if (m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    state         <= RD_D;
                end
                RD_D: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_err      <= 1'b0;
                    rsp_rdata    <= m_axi_rdata;
                    state        <= RSP;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4l_master_bridge.sv
// tb_axi4l_master_bridge: randomized self-checking bench with a transaction-level model and a memory slave
module tb_axi4l_master_bridge;
    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0] cmd_wstrb;
    logic rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0] m_axi_wstrb;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi4l_master_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int vecs = 0, errs = 0;
    int cyc = 0, acc_cyc = 0, rsp_cyc = 0;
    bit zw;
    int w_lag, ar_lag, r_lag, rsp_lag;
    bit pend, p_we;
    logic [31:0] p_a, p_d;
    logic [3:0] p_s;
    // kind: 0 idle, 1 write on bus, 2 read on bus, 3 response pending
    int kind;
    bit busy, aw_got, w_got, ar_done, rd_pend, rd_phase, rsp_phase, e_err, last_err;
    logic [31:0] cur_a, cur_d, e_rdata, last_rdata, aw_a, w_d, rd_a;
    logic [3:0] cur_s, w_s;
    int w_cnt, ar_cnt, r_cnt, r_need, rsp_cnt;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic cycle();
        bit exp_aw, exp_w, exp_ar;
        @(negedge clk);
        cyc++;
        exp_aw = kind == 1 && !aw_got;
        exp_w  = kind == 1 && !w_got;
        exp_ar = kind == 2 && !ar_done;
        chk("cmd_ready", cmd_ready, !busy);
        chk("valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, rsp_valid},
            {exp_aw, exp_w, exp_ar, rd_phase, rsp_phase});
        if (exp_aw) chk("awaddr", m_axi_awaddr, cur_a & ~32'h3);
        if (exp_w) chk("wdata", {m_axi_wstrb, m_axi_wdata}, {cur_s, cur_d});
        if (exp_ar) chk("araddr", m_axi_araddr, cur_a & ~32'h3);
        if (rsp_phase) chk("rsp", {rsp_err, rsp_rdata}, {e_err, e_rdata});
        if (rsp_phase) begin
            if (rsp_cnt == 0) rsp_cyc = cyc;
            rsp_ready = zw ? rsp_cnt >= rsp_lag : $urandom_range(1) == 1;
            rsp_cnt++;
            if (rsp_ready) begin
                last_err = rsp_err;
                last_rdata = rsp_rdata;
                rsp_phase = 0;
                busy = 0;
                kind = 0;
            end
        end else rsp_ready = !zw && $urandom_range(1) == 1;
        if (!busy && pend) begin
            cmd_valid = 1'b1;
            cmd_addr = p_a;
            cmd_we = p_we;
            cmd_wdata = p_d;
            cmd_wstrb = p_s;
            if (cmd_ready) begin
                pend = 0;
                busy = 1;
                acc_cyc = cyc;
                cur_a = p_a;
                cur_d = p_d;
                cur_s = p_s;
                aw_got = 0;
                w_got = 0;
                ar_done = 0;
                w_cnt = 0;
                ar_cnt = 0;
                rsp_cnt = 0;
                e_err = p_a[1:0] != 2'b00;
                e_rdata = 32'h0;
                if (e_err) begin
                    kind = 3;
                    rsp_phase = 1;
                end else if (p_we) begin
                    kind = 1;
                    ref_mem[p_a[9:2]] = merge(ref_mem[p_a[9:2]], p_d, p_s);
                end else begin
                    kind = 2;
                    e_rdata = ref_mem[p_a[9:2]];
                end
            end
        end else begin
            cmd_valid = busy && $urandom_range(1) == 1;
            cmd_addr = $urandom;
            cmd_we = $urandom_range(1) == 1;
            cmd_wdata = $urandom;
            cmd_wstrb = 4'($urandom);
        end
        m_axi_awready = m_axi_awvalid && (zw || $urandom_range(1) == 1);
        m_axi_wready = m_axi_wvalid && (zw ? w_cnt >= w_lag : $urandom_range(1) == 1);
        if (m_axi_wvalid) w_cnt++;
        if (kind == 1) begin
            if (m_axi_awvalid && m_axi_awready && !aw_got) begin
                aw_got = 1;
                aw_a = m_axi_awaddr;
            end
            if (m_axi_wvalid && m_axi_wready && !w_got) begin
                w_got = 1;
                w_d = m_axi_wdata;
                w_s = m_axi_wstrb;
            end
            if (aw_got && w_got) begin
                mem[aw_a[9:2]] = merge(mem[aw_a[9:2]], w_d, w_s);
                kind = 3;
                rsp_phase = 1;
            end
        end
        if (rd_pend) begin
            if (r_cnt < r_need) begin
                r_cnt++;
                m_axi_rvalid = 1'b0;
            end else begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata = mem[rd_a[9:2]];
                if (m_axi_rready) begin
                    rd_pend = 0;
                    rd_phase = 0;
                    kind = 3;
                    rsp_phase = 1;
                end
            end
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata = $urandom;
        end
        m_axi_arready = m_axi_arvalid && (zw ? ar_cnt >= ar_lag : $urandom_range(1) == 1);
        if (m_axi_arvalid) ar_cnt++;
        if (kind == 2 && !ar_done && m_axi_arvalid && m_axi_arready) begin
            ar_done = 1;
            rd_pend = 1;
            rd_a = m_axi_araddr;
            r_cnt = 0;
            r_need = zw ? r_lag : $urandom_range(3);
            rd_phase = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        {pend, busy, aw_got, w_got, ar_done, rd_pend, rd_phase, rsp_phase} = '0;
        kind = 0;
        @(negedge clk);
        cyc++;
        chk("rst_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready}, 6'b000001);
        rst = 1'b0;
    endtask

    task automatic run_cmd(input logic [31:0] a, input bit we, input logic [31:0] d, input logic [3:0] s,
                           input int exp_lat);
        int n = 0;
        pend = 1;
        p_a = a;
        p_we = we;
        p_d = d;
        p_s = s;
        do begin
            cycle();
            n++;
        end while ((pend || busy) && n < 200);
        chk("done", {pend, busy}, 0);
        if (pend || busy) do_reset();
        else if (exp_lat >= 0) chk("latency", rsp_cyc - acc_cyc, exp_lat);
    endtask

    initial begin
        logic [31:0] a;
        int n;
        rst = 1'b1;
        {cmd_valid, cmd_we, rsp_ready, m_axi_awready, m_axi_wready, m_axi_arready, m_axi_rvalid} = '0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        m_axi_rdata = '0;
        {zw, pend, busy, aw_got, w_got, ar_done, rd_pend, rd_phase, rsp_phase} = '0;
        kind = 0;
        {w_lag, ar_lag, r_lag, rsp_lag} = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_ctl", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, rsp_valid, rsp_err},
            7'b1000000);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 0);
        chk("rst_wdata", {m_axi_wstrb, m_axi_wdata}, 0);
        rst = 1'b0;
        zw = 1;
        run_cmd(32'h10, 1, 32'hDEADBEEF, 4'hF, 2);
        run_cmd(32'h10, 0, 32'h0, 4'h0, 3);
        chk("rd_back", {last_err, last_rdata}, {1'b0, 32'hDEADBEEF});
        w_lag = 2;
        run_cmd(32'h44, 1, 32'h1234_5678, 4'h5, 4);
        w_lag = 0;
        ar_lag = 3;
        rsp_lag = 2;
        run_cmd(32'h44, 0, 32'h0, 4'h0, 6);
        ar_lag = 0;
        rsp_lag = 0;
        run_cmd(32'h6, 0, 32'h0, 4'h0, 1);
        chk("misaligned", {last_err, last_rdata}, {1'b1, 32'h0});
        r_lag = 20;
        pend = 1;
        p_a = 32'h30;
        p_we = 0;
        n = 0;
        while (!rd_phase && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        chk("in_rd_d", {m_axi_rready, rsp_valid}, 2'b10);
        do_reset();
        r_lag = 0;
        run_cmd(32'h20, 0, 32'h0, 4'h0, 3);
        chk("post_rst_rd", {last_err, last_rdata}, {1'b0, ref_mem[8]});
        zw = 0;
        repeat (300) begin
            a = $urandom;
            if ($urandom_range(7) != 0) a[1:0] = 2'b00;
            run_cmd(a, $urandom_range(1) == 1, $urandom, 4'($urandom), -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
